// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: load/store funct3 width codes and the LSU FSM state type.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: F3_* funct3 codes (also used by the core decoder), lsu_state_t,
//           f3_legal() and f3_misaligned() access-check helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // Unsigned codes only make sense for loads; 64-bit forms only exist on RV64.
    function automatic logic f3_legal(input logic [2:0] f3, input logic write, input int xlen);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !write;
            F3_D:             ok = (xlen == 64);
            F3_WU:            ok = (xlen == 64) && !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct3[1:0] encodes log2 of the access size in bytes.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] lsb);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = lsb[0];
            2'd2:    mis = (lsb[1:0] != 2'b00);
            2'd3:    mis = (lsb != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: write byte enables, write data shift, read extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
// Ports: funct3/off in (access code, byte offset in word), wdata/rword in (store data,
//        addressed memory word), be/wdata_sh/rdata out (lane mask, shifted store, load result).
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]              funct3,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]         wdata,
    input  logic [XLEN-1:0]         rword,
    output logic [XLEN/8-1:0]       be,
    output logic [XLEN-1:0]         wdata_sh,
    output logic [XLEN-1:0]         rdata
);

    localparam int NB = XLEN / 8;

    int                nbytes;
    int                nbits;
    logic [NB-1:0]     be_base;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   mask;
    logic              is_unsigned;
    logic              sign;

    always_comb begin
        nbytes      = 1 << funct3[1:0];
        nbits       = nbytes * 8;
        is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU) || (funct3 == F3_WU);

        be_base = '0;
        for (int i = 0; i < NB; i++) begin
            be_base[i] = (i < nbytes);
        end
        be       = be_base << off;
        wdata_sh = wdata << {off, 3'b000};

        // Bring the addressed lane down to bit 0, then mask and extend.
        shifted = rword >> {off, 3'b000};
        mask    = '1;
        sign    = 1'b0;
        if (nbits < XLEN) begin
            mask = ~({XLEN{1'b1}} << nbits);
            sign = !is_unsigned && ((shifted & (XLEN'(1) << (nbits - 1))) != '0);
        end
        rdata = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store unit with integrated byte-addressable XLEN-wide data memory and error checks.
// Latency: WAIT_STATES+1 cycles from request accept to resp_valid; no back-to-back accepts.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
// Ports: clk, reset (sync active-low); req_valid/req_ready/req_write/req_funct3/req_addr/
//        req_wdata request side; resp_valid/resp_ready/resp_rdata/resp_err response side.
module lsu_data_mem
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int NB        = XLEN / 8;
    localparam int OFF_W     = $clog2(NB);
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int ADDR_USED = OFF_W + IDX_W;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    lsu_state_t       state;
    lsu_state_t       state_nx;
    logic [3:0]       wait_cnt;

    logic             hold_write;
    logic [2:0]       hold_funct3;
    logic [XLEN-1:0]  hold_addr;
    logic [XLEN-1:0]  hold_wdata;

    logic [XLEN-1:0]  memory [0:DEPTH_WORDS-1];

    logic             accept;
    logic             enter_resp;
    logic             src_write;
    logic [2:0]       src_funct3;
    logic [XLEN-1:0]  src_addr;
    logic [XLEN-1:0]  src_wdata;
    logic [IDX_W-1:0] src_idx;
    logic [OFF_W-1:0] src_off;
    logic             range_err;
    logic             acc_err;
    logic [XLEN-1:0]  rword;
    logic [NB-1:0]    be;
    logic [XLEN-1:0]  wdata_sh;
    logic [XLEN-1:0]  rdata_ext;

    assign req_ready  = (state == LSU_IDLE);
    assign resp_valid = (state == LSU_RESP);
    assign accept     = req_ready && req_valid;

    always_comb begin
        state_nx = state;
        case (state)
            LSU_IDLE: if (req_valid) state_nx = (WAIT_STATES > 0) ? LSU_WAIT : LSU_RESP;
            LSU_WAIT: if (wait_cnt == 4'd0) state_nx = LSU_RESP;
            LSU_RESP: if (resp_ready) state_nx = LSU_IDLE;
            default:  state_nx = LSU_IDLE;
        endcase
    end

    // With zero wait states the accept edge is also the RESP entry edge, so the
    // access must see the live request rather than the not-yet-loaded holding regs.
    assign enter_resp = (state_nx == LSU_RESP) && (state != LSU_RESP);
    assign src_write  = (state == LSU_IDLE) ? req_write  : hold_write;
    assign src_funct3 = (state == LSU_IDLE) ? req_funct3 : hold_funct3;
    assign src_addr   = (state == LSU_IDLE) ? req_addr   : hold_addr;
    assign src_wdata  = (state == LSU_IDLE) ? req_wdata  : hold_wdata;

    assign src_idx   = src_addr[OFF_W +: IDX_W];
    assign src_off   = src_addr[OFF_W-1:0];
    // DEPTH_WORDS is a power of two, so any set bit above the index means out of range.
    assign range_err = (src_addr >> ADDR_USED) != '0;
    assign acc_err   = !f3_legal(src_funct3, src_write, XLEN)
                     || f3_misaligned(src_funct3, src_addr[2:0])
                     || range_err;
    assign rword     = memory[src_idx];

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3   (src_funct3),
        .off      (src_off),
        .wdata    (src_wdata),
        .rword    (rword),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= LSU_IDLE;
            wait_cnt    <= 4'd0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            hold_write  <= 1'b0;
            hold_funct3 <= 3'b000;
            hold_addr   <= '0;
            hold_wdata  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                hold_write  <= req_write;
                hold_funct3 <= req_funct3;
                hold_addr   <= req_addr;
                hold_wdata  <= req_wdata;
            end
            if (accept && (WAIT_STATES > 0)) begin
                wait_cnt <= WS_LOAD;
            end else if ((state == LSU_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || src_write) ? '0 : rdata_ext;
            end
        end
    end

    // Storage is never cleared; reset only blocks a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && src_write && !acc_err) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    memory[src_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
module tb_lsu_data_mem;
    import riscv_pkg::*;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_chk;
    int n_fail;
    int ws [2];
    vec_t vt[$];

    lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) d0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) d3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vt.push_back(v);
    endtask

    // Called #1 after a clock edge; returns #1 after the response handshake edge.
    // lat counts edges after the accept edge before resp_valid is seen.
    task automatic xact(input int s, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_write[s] = wr; req_funct3[s] = f3; req_addr[s] = a; req_wdata[s] = wd;
        req_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready[s]) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready stuck at 0, required 1", s);
        end
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 0;
        while (!resp_valid[s] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid[s]) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout dut%0d: resp_valid stuck at 0, required 1", s);
        end
        rd = resp_rdata[s];
        er = resp_err[s];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        n_chk = 0; n_fail = 0;
        ws[0] = 0; ws[1] = 3;
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_write[s] = 1'b0; req_funct3[s] = 3'b000;
            req_addr[s] = '0; req_wdata[s] = '0; resp_ready[s] = 1'b1;
        end

        add(1, F3_W,  32'h0,        32'hCAFEF00D, 32'h0,        0);
        add(1, F3_W,  32'h8,        32'h0,        32'h0,        0);
        add(1, F3_B,  32'h8,        32'hAAAAAAAA, 32'h0,        0);
        add(0, F3_W,  32'h8,        32'h0,        32'h000000AA, 0);
        add(1, F3_W,  32'hC,        32'hBBBBBBBB, 32'h0,        0);
        add(0, F3_B,  32'hC,        32'h0,        32'hFFFFFFBB, 0);
        add(0, F3_BU, 32'hF,        32'h0,        32'h000000BB, 0);
        add(0, F3_H,  32'hE,        32'h0,        32'hFFFFBBBB, 0);
        add(1, F3_W,  32'h10,       32'h55555555, 32'h0,        0);
        add(1, F3_H,  32'h12,       32'h00001234, 32'h0,        0);
        add(0, F3_W,  32'h10,       32'h0,        32'h12345555, 0);
        add(0, F3_H,  32'h12,       32'h0,        32'h00001234, 0);
        add(0, F3_W,  32'h5,        32'h0,        32'h0,        1);
        add(1, F3_H,  32'h3,        32'hFFFFFFFF, 32'h0,        1);
        add(0, F3_W,  32'h0,        32'h0,        32'hCAFEF00D, 0);
        add(0, F3_HU, 32'h2,        32'h0,        32'h0000CAFE, 0);
        add(0, F3_H,  32'h2,        32'h0,        32'hFFFFCAFE, 0);
        add(0, F3_B,  32'h1,        32'h0,        32'hFFFFFFF0, 0);
        add(1, F3_W,  32'h3FC,      32'h01020304, 32'h0,        0);
        add(0, F3_W,  32'h3FC,      32'h0,        32'h01020304, 0);
        add(0, F3_BU, 32'h3FD,      32'h0,        32'h00000003, 0);
        add(0, F3_W,  32'h400,      32'h0,        32'h0,        1);
        add(1, F3_W,  32'h400,      32'h00000001, 32'h0,        1);
        add(0, F3_W,  32'h80000000, 32'h0,        32'h0,        1);
        add(0, F3_W,  32'h0,        32'h0,        32'hCAFEF00D, 0);
        add(0, F3_D,  32'h0,        32'h0,        32'h0,        1);
        add(0, F3_WU, 32'h0,        32'h0,        32'h0,        1);
        add(0, 3'b111, 32'h0,       32'h0,        32'h0,        1);
        add(1, F3_BU, 32'h8,        32'h000000FF, 32'h0,        1);
        add(0, F3_W,  32'h8,        32'h0,        32'h000000AA, 0);
        add(1, F3_B,  32'h9,        32'h00000077, 32'h0,        0);
        add(0, F3_HU, 32'h8,        32'h0,        32'h000077AA, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_req_ready%0d", s),  32'(req_ready[s]),  32'h1);
            chk($sformatf("rst_resp_valid%0d", s), 32'(resp_valid[s]), 32'h0);
            chk($sformatf("rst_resp_rdata%0d", s), resp_rdata[s],      32'h0);
            chk($sformatf("rst_resp_err%0d", s),   32'(resp_err[s]),   32'h0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < vt.size(); i++) begin
                xact(s, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
                chk($sformatf("dut%0d_v%0d_rdata", s, i), rd, vt[i].exp_rdata);
                chk($sformatf("dut%0d_v%0d_err", s, i), 32'(er), 32'(vt[i].exp_err));
                chk($sformatf("dut%0d_v%0d_latency", s, i), 32'(lat + 1), 32'(ws[s] + 1));
                chk($sformatf("dut%0d_v%0d_ready_after", s, i), 32'(req_ready[s]), 32'h1);
            end
        end

        // Wait states plus response backpressure on the 3-wait-state unit.
        xact(1, 1'b1, F3_W, 32'h20, 32'h11223344, rd, er, lat);
        resp_ready[1] = 1'b0;
        req_write[1] = 1'b0; req_funct3[1] = F3_W; req_addr[1] = 32'h20; req_wdata[1] = 32'h0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_wait%0d_valid", k), 32'(resp_valid[1]), 32'h0);
            chk($sformatf("bp_wait%0d_ready", k), 32'(req_ready[1]), 32'h0);
            @(posedge clk); #1;
        end
        chk("bp_valid_rise", 32'(resp_valid[1]), 32'h1);
        chk("bp_rdata", resp_rdata[1], 32'h11223344);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", k), 32'(resp_valid[1]), 32'h1);
            chk($sformatf("bp_hold%0d_rdata", k), resp_rdata[1], 32'h11223344);
            chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready[1]), 32'h0);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_valid", 32'(resp_valid[1]), 32'h0);
        chk("bp_done_ready", 32'(req_ready[1]), 32'h1);

        // Reset during WAIT drops the pending store.
        xact(1, 1'b1, F3_W, 32'h0, 32'h5A5A5A5A, rd, er, lat);
        req_write[1] = 1'b1; req_funct3[1] = F3_W; req_addr[1] = 32'h0; req_wdata[1] = 32'hDEADBEEF;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("rw_in_wait", 32'(req_ready[1]), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rw_idle_ready", 32'(req_ready[1]), 32'h1);
        chk("rw_idle_valid", 32'(resp_valid[1]), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset low exactly on the RESP entry edge: the store must not land.
        req_wdata[1] = 32'h12345678;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("re_idle_ready", 32'(req_ready[1]), 32'h1);
        chk("re_idle_valid", 32'(resp_valid[1]), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        xact(1, 1'b0, F3_W, 32'h0, 32'h0, rd, er, lat);
        chk("reset_mem_kept", rd, 32'h5A5A5A5A);
        chk("reset_mem_err", 32'(er), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
